multicycle_control: RTL and testbench

- Multicycle RV32I main control unit: a Moore/Mealy FSM that sequences Fetch, Decode, Execute, Memory and Writeback over several clocks.
- Replaces the single-cycle opcode decoder in the multicycle datapath.
- Generates per-cycle datapath enables and mux selects.
- Supports a parametrised memory ready/wait handshake, optional U-type instructions, an illegal-opcode flag and a retired-instruction counter.

---
 rtl/multicycle_control_pkg.sv | 55 +++++
 rtl/mc_output_decode.sv | 83 ++++++++
 rtl/multicycle_control.sv | 125 ++++++++++++
 tb/tb_multicycle_control.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle RV32I control unit: opcodes, FSM states,
// datapath select codes and the packed control word passed between modules.
package multicycle_control_pkg;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_EXEC_U   = 4'd5,
    S_WB_ALU   = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_MEM_WB   = 4'd9,
    S_MEM_WR   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JAL      = 4'd12,
    S_JALR     = 4'd13
  } state_t;

  typedef enum logic [1:0] {M2R_ALUOUT = 2'd0, M2R_MDR  = 2'd1, M2R_PC    = 2'd2} memtoreg_t;
  typedef enum logic [1:0] {SRCA_PC    = 2'd0, SRCA_RS1 = 2'd1, SRCA_ZERO = 2'd2} srca_t;
  typedef enum logic [1:0] {SRCB_RS2   = 2'd0, SRCB_FOUR = 2'd1, SRCB_IMM = 2'd2} srcb_t;
  typedef enum logic [1:0] {ALU_ADD    = 2'd0, ALU_SUB  = 2'd1, ALU_FUNCT = 2'd2} aluop_t;
  typedef enum logic [1:0] {PCS_ALU    = 2'd0, PCS_ALUOUT = 2'd1, PCS_JALR = 2'd2} pcsrc_t;

  typedef struct packed {
    logic      pc_write;
    logic      pc_write_cond;
    logic      iord;
    logic      mem_read;
    logic      mem_write;
    logic      ir_write;
    memtoreg_t memtoreg;
    logic      reg_write;
    srca_t     alu_src_a;
    srcb_t     alu_src_b;
    aluop_t    alu_op;
    pcsrc_t    pc_source;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/mc_output_decode.sv
// Combinational control-word decode: current state plus memory ready (and the
// opcode, for LUI/AUIPC operand selection) to per-cycle datapath controls.
module mc_output_decode
  import multicycle_control_pkg::*;
(
  input  logic [3:0]        state,
  input  logic [6:0]        opcode,
  input  logic              mem_ready,
  output logic [CTRL_W-1:0] ctrl
);

  ctrl_t c;

  always_comb begin
    // NOTE: every field defaults to 0 before the case, so no state can infer a latch.
    c = '0;
    case (state_t'(state))
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        // IR and PC only load on the cycle the memory actually returns the word.
        c.ir_write  = mem_ready;
        c.pc_write  = mem_ready;
      end
      S_DECODE: c.alu_src_b = SRCB_IMM;
      S_EXEC_R: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_op    = ALU_FUNCT;
      end
      S_EXEC_I: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_FUNCT;
      end
      S_EXEC_U: begin
        if (opcode == OPC_LUI) c.alu_src_a = SRCA_ZERO;
        else                   c.alu_src_a = SRCA_PC;
        c.alu_src_b = SRCB_IMM;
      end
      S_WB_ALU: c.reg_write = 1'b1;
      S_MEM_ADDR: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write = 1'b1;
        c.memtoreg  = M2R_MDR;
      end
      S_MEM_WR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = SRCA_RS1;
        c.alu_op        = ALU_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCS_ALUOUT;
      end
      S_JAL: begin
        c.reg_write = 1'b1;
        c.memtoreg  = M2R_PC;
        c.pc_write  = 1'b1;
        c.pc_source = PCS_ALUOUT;
      end
      S_JALR: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        c.reg_write = 1'b1;
        c.memtoreg  = M2R_PC;
        c.pc_write  = 1'b1;
        c.pc_source = PCS_JALR;
      end
      default: c = '0;
    endcase
  end

  assign ctrl = c;

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I main control: FSM sequencing, sticky illegal-opcode flag and
// retired-instruction counter; output decode lives in mc_output_decode.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit ENABLE_UTYPE  = 1'b1,
  parameter int CNT_W         = 32
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic [6:0]       iOPCODE,
  input  logic             iMemReady,
  output logic             oPCWrite,
  output logic             oPCWriteCond,
  output logic             oIorD,
  output logic             oMemRead,
  output logic             oMemWrite,
  output logic             oIRWrite,
  output logic [1:0]       oMemtoReg,
  output logic             oRegWrite,
  output logic [1:0]       oALUSrcA,
  output logic [1:0]       oALUSrcB,
  output logic [1:0]       oALUOp,
  output logic [1:0]       oPCSource,
  output logic             oIllegal,
  output logic [3:0]       oState,
  output logic [CNT_W-1:0] oInstret
);

  state_t            state, state_nxt;
  logic              ready;
  logic              retire;
  logic              bad_opc;
  logic              illegal;
  logic [CNT_W-1:0]  instret;
  logic [CTRL_W-1:0] ctrl_bits;
  ctrl_t             ctrl;

  assign ready = MEM_HANDSHAKE ? iMemReady : 1'b1;

  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    bad_opc   = 1'b0;
    case (state)
      S_IDLE:  state_nxt = S_FETCH;
      S_FETCH: if (ready) state_nxt = S_DECODE;
      S_DECODE: begin
        case (iOPCODE)
          OPC_RTYPE:           state_nxt = S_EXEC_R;
          OPC_OPIMM:           state_nxt = S_EXEC_I;
          OPC_LOAD, OPC_STORE: state_nxt = S_MEM_ADDR;
          OPC_BRANCH:          state_nxt = S_BRANCH;
          OPC_JAL:             state_nxt = S_JAL;
          OPC_JALR:            state_nxt = S_JALR;
          OPC_LUI, OPC_AUIPC: begin
            if (ENABLE_UTYPE) begin
              state_nxt = S_EXEC_U;
            end else begin
              state_nxt = S_FETCH;
              bad_opc   = 1'b1;
            end
          end
          default: begin
            state_nxt = S_FETCH;
            bad_opc   = 1'b1;
          end
        endcase
      end
      S_EXEC_R, S_EXEC_I, S_EXEC_U: state_nxt = S_WB_ALU;
      S_MEM_ADDR: state_nxt = (iOPCODE == OPC_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (ready) state_nxt = S_MEM_WB;
      S_MEM_WR: begin
        if (ready) begin
          state_nxt = S_FETCH;
          retire    = 1'b1;
        end
      end
      S_WB_ALU, S_MEM_WB, S_BRANCH, S_JAL, S_JALR: begin
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state   <= S_IDLE;
      illegal <= 1'b0;
      instret <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state <= state_nxt;
      if (bad_opc) illegal <= 1'b1;
      if (retire)  instret <= instret + CNT_W'(1);
    end
  end

  mc_output_decode u_decode (
    .state     (state),
    .opcode    (iOPCODE),
    .mem_ready (ready),
    .ctrl      (ctrl_bits)
  );

  assign ctrl         = ctrl_t'(ctrl_bits);
  assign oPCWrite     = ctrl.pc_write;
  assign oPCWriteCond = ctrl.pc_write_cond;
  assign oIorD        = ctrl.iord;
  assign oMemRead     = ctrl.mem_read;
  assign oMemWrite    = ctrl.mem_write;
  assign oIRWrite     = ctrl.ir_write;
  assign oMemtoReg    = ctrl.memtoreg;
  assign oRegWrite    = ctrl.reg_write;
  assign oALUSrcA     = ctrl.alu_src_a;
  assign oALUSrcB     = ctrl.alu_src_b;
  assign oALUOp       = ctrl.alu_op;
  assign oPCSource    = ctrl.pc_source;
  assign oIllegal     = illegal;
  assign oState       = state;
  assign oInstret     = instret;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: expected state/ready steps are queued
// per instruction and popped each cycle against an independent control model.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  logic       iCLK = 1'b0;
  logic       iRST_N = 1'b1;
  logic [6:0] iOPCODE = OPC_RTYPE;
  logic       iMemReady = 1'b1;

  logic        oPCWrite, oPCWriteCond, oIorD, oMemRead, oMemWrite, oIRWrite, oRegWrite, oIllegal;
  logic [1:0]  oMemtoReg, oALUSrcA, oALUSrcB, oALUOp, oPCSource;
  logic [3:0]  oState;
  logic [31:0] oInstret;

  logic        d2_PCWrite, d2_PCWriteCond, d2_IorD, d2_MemRead, d2_MemWrite, d2_IRWrite, d2_RegWrite, d2_Illegal;
  logic [1:0]  d2_MemtoReg, d2_ALUSrcA, d2_ALUSrcB, d2_ALUOp, d2_PCSource;
  logic [3:0]  d2_State;
  logic [3:0]  d2_Instret;

  multicycle_control dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iOPCODE(iOPCODE), .iMemReady(iMemReady),
    .oPCWrite(oPCWrite), .oPCWriteCond(oPCWriteCond), .oIorD(oIorD),
    .oMemRead(oMemRead), .oMemWrite(oMemWrite), .oIRWrite(oIRWrite),
    .oMemtoReg(oMemtoReg), .oRegWrite(oRegWrite), .oALUSrcA(oALUSrcA),
    .oALUSrcB(oALUSrcB), .oALUOp(oALUOp), .oPCSource(oPCSource),
    .oIllegal(oIllegal), .oState(oState), .oInstret(oInstret)
  );

  // Second instance: no handshake, no U-type, narrow counter.
  multicycle_control #(.MEM_HANDSHAKE(1'b0), .ENABLE_UTYPE(1'b0), .CNT_W(4)) dut2 (
    .iCLK(iCLK), .iRST_N(iRST_N), .iOPCODE(iOPCODE), .iMemReady(iMemReady),
    .oPCWrite(d2_PCWrite), .oPCWriteCond(d2_PCWriteCond), .oIorD(d2_IorD),
    .oMemRead(d2_MemRead), .oMemWrite(d2_MemWrite), .oIRWrite(d2_IRWrite),
    .oMemtoReg(d2_MemtoReg), .oRegWrite(d2_RegWrite), .oALUSrcA(d2_ALUSrcA),
    .oALUSrcB(d2_ALUSrcB), .oALUOp(d2_ALUOp), .oPCSource(d2_PCSource),
    .oIllegal(d2_Illegal), .oState(d2_State), .oInstret(d2_Instret)
  );

  always #5 iCLK = ~iCLK;

  logic [16:0] dut_ctrl;
  assign dut_ctrl = {oPCWrite, oPCWriteCond, oIorD, oMemRead, oMemWrite, oIRWrite,
                     oMemtoReg, oRegWrite, oALUSrcA, oALUSrcB, oALUOp, oPCSource};

  typedef struct {
    logic [3:0] st;
    logic       rdy;
  } step_t;

  step_t exp_q[$];
  int checks   = 0;
  int failures = 0;
  int rw_cnt, rd_cnt, irw_cnt, wr_cnt;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Control word each state should drive, written from the state table.
  function automatic logic [16:0] exp_ctrl(input logic [3:0] st, input logic rdy, input logic [6:0] opc);
    logic pcw = 1'b0, pcwc = 1'b0, iord = 1'b0, mrd = 1'b0, mwr = 1'b0, irw = 1'b0, rw = 1'b0;
    logic [1:0] m2r = 2'd0, sa = 2'd0, sb = 2'd0, op = 2'd0, ps = 2'd0;
    case (st)
      S_FETCH:    begin mrd = 1'b1; sb = 2'd1; irw = rdy; pcw = rdy; end
      S_DECODE:   sb = 2'd2;
      S_EXEC_R:   begin sa = 2'd1; op = 2'd2; end
      S_EXEC_I:   begin sa = 2'd1; sb = 2'd2; op = 2'd2; end
      S_EXEC_U:   begin sa = (opc == 7'b0110111) ? 2'd2 : 2'd0; sb = 2'd2; end
      S_WB_ALU:   rw = 1'b1;
      S_MEM_ADDR: begin sa = 2'd1; sb = 2'd2; end
      S_MEM_RD:   begin mrd = 1'b1; iord = 1'b1; end
      S_MEM_WB:   begin rw = 1'b1; m2r = 2'd1; end
      S_MEM_WR:   begin mwr = 1'b1; iord = 1'b1; end
      S_BRANCH:   begin sa = 2'd1; op = 2'd1; pcwc = 1'b1; ps = 2'd1; end
      S_JAL:      begin rw = 1'b1; m2r = 2'd2; pcw = 1'b1; ps = 2'd1; end
      S_JALR:     begin sa = 2'd1; sb = 2'd2; rw = 1'b1; m2r = 2'd2; pcw = 1'b1; ps = 2'd2; end
      default:    ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, sa, sb, op, ps};
  endfunction

  task automatic push(input logic [3:0] st, input logic rdy);
    step_t e;
    e.st  = st;
    e.rdy = rdy;
    exp_q.push_back(e);
  endtask

  task automatic push_instr(input logic [6:0] opc);
    push(S_FETCH, 1'b1);
    push(S_DECODE, 1'b1);
    case (opc)
      OPC_RTYPE:  begin push(S_EXEC_R, 1'b1); push(S_WB_ALU, 1'b1); end
      OPC_OPIMM:  begin push(S_EXEC_I, 1'b1); push(S_WB_ALU, 1'b1); end
      OPC_LUI, OPC_AUIPC: begin push(S_EXEC_U, 1'b1); push(S_WB_ALU, 1'b1); end
      OPC_BRANCH: push(S_BRANCH, 1'b1);
      OPC_JAL:    push(S_JAL, 1'b1);
      OPC_JALR:   push(S_JALR, 1'b1);
      default:    ;
    endcase
  endtask

  // Pops one expected step per cycle; called at a falling edge.
  task automatic drain(input string tag);
    step_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      iMemReady = e.rdy;
      #1;
      check($sformatf("%s_state", tag), 32'(oState), 32'(e.st));
      check($sformatf("%s_ctrl_s%0d", tag, e.st), 32'(dut_ctrl), 32'(exp_ctrl(e.st, e.rdy, iOPCODE)));
      if (oRegWrite) rw_cnt++;
      if (oMemRead && oIorD) rd_cnt++;
      if (oIRWrite) irw_cnt++;
      if (oMemWrite) wr_cnt++;
      @(negedge iCLK);
    end
  endtask

  task automatic do_reset();
    iRST_N = 1'b0;
    #1;
    check("rst_state", 32'(oState), 32'(S_IDLE));
    check("rst_ctrl", 32'(dut_ctrl), 32'd0);
    check("rst_illegal", 32'(oIllegal), 32'd0);
    check("rst_instret", oInstret, 32'd0);
    rw_cnt = 0; rd_cnt = 0; irw_cnt = 0; wr_cnt = 0;
    @(negedge iCLK);
    iRST_N = 1'b1;
    push(S_IDLE, 1'b1);
  endtask

  initial begin
    @(negedge iCLK);

    // R-type, ready tied high
    do_reset();
    iOPCODE = OPC_RTYPE;
    push_instr(OPC_RTYPE);
    drain("rtype");
    check("rtype_end_state", 32'(oState), 32'(S_FETCH));
    check("rtype_regwrite_cycles", 32'(rw_cnt), 32'd1);
    check("rtype_instret", oInstret, 32'd1);

    // LOAD with three wait cycles in S_MEM_RD
    do_reset();
    iOPCODE = OPC_LOAD;
    push(S_FETCH, 1'b1); push(S_DECODE, 1'b1); push(S_MEM_ADDR, 1'b1);
    for (int i = 0; i < 3; i++) push(S_MEM_RD, 1'b0);
    push(S_MEM_RD, 1'b1); push(S_MEM_WB, 1'b1);
    drain("load");
    check("load_rd_cycles", 32'(rd_cnt), 32'd4);
    check("load_instret", oInstret, 32'd1);

    // STORE with two fetch wait cycles
    do_reset();
    iOPCODE = OPC_STORE;
    push(S_FETCH, 1'b0); push(S_FETCH, 1'b0); push(S_FETCH, 1'b1);
    push(S_DECODE, 1'b1); push(S_MEM_ADDR, 1'b1); push(S_MEM_WR, 1'b1);
    drain("store");
    check("store_irwrite_cycles", 32'(irw_cnt), 32'd1);
    check("store_memwrite_cycles", 32'(wr_cnt), 32'd1);
    check("store_regwrite_cycles", 32'(rw_cnt), 32'd0);
    check("store_instret", oInstret, 32'd1);

    // Illegal opcode, then an addi
    do_reset();
    iOPCODE = 7'b1111111;
    push_instr(7'b1111111);
    drain("illegal");
    check("illegal_state", 32'(oState), 32'(S_FETCH));
    check("illegal_flag", 32'(oIllegal), 32'd1);
    check("illegal_instret", oInstret, 32'd0);
    iOPCODE = OPC_OPIMM;
    push_instr(OPC_OPIMM);
    drain("addi");
    check("illegal_sticky", 32'(oIllegal), 32'd1);
    check("addi_instret", oInstret, 32'd1);

    // U-type on main DUT; second instance treats LUI as illegal
    do_reset();
    iOPCODE = OPC_LUI;
    push_instr(OPC_LUI);
    drain("lui");
    check("lui_illegal", 32'(oIllegal), 32'd0);
    check("lui_instret", oInstret, 32'd1);
    check("d2_lui_illegal", 32'(d2_Illegal), 32'd1);
    check("d2_lui_instret", 32'(d2_Instret), 32'd0);
    iOPCODE = OPC_AUIPC;  push_instr(OPC_AUIPC);  drain("auipc");
    iOPCODE = OPC_BRANCH; push_instr(OPC_BRANCH); drain("branch");
    iOPCODE = OPC_JAL;    push_instr(OPC_JAL);    drain("jal");
    iOPCODE = OPC_JALR;   push_instr(OPC_JALR);   drain("jalr");
    check("mix_instret", oInstret, 32'd5);

    // Reset dropped while a store waits in S_MEM_WR
    do_reset();
    iOPCODE = OPC_OPIMM;
    push_instr(OPC_OPIMM);
    drain("pre_addi");
    iOPCODE = OPC_STORE;
    push(S_FETCH, 1'b1); push(S_DECODE, 1'b1); push(S_MEM_ADDR, 1'b1); push(S_MEM_WR, 1'b0);
    drain("wr_wait");
    check("wr_wait_state", 32'(oState), 32'(S_MEM_WR));
    check("wr_wait_memwrite", 32'(oMemWrite), 32'd1);
    check("wr_wait_instret", oInstret, 32'd1);
    #2;
    do_reset();
    iMemReady = 1'b1;
    drain("post_rst");

    // 17 addi: 4-bit counter wraps to 1
    do_reset();
    iOPCODE = OPC_OPIMM;
    for (int i = 0; i < 17; i++) push_instr(OPC_OPIMM);
    drain("wrap");
    check("wrap_instret32", oInstret, 32'd17);
    check("wrap_instret4", 32'(d2_Instret), 32'd1);
    check("wrap_d2_state", 32'(d2_State), 32'(S_FETCH));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
